cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports listed clock and reset first.
REQ-002 Port list (name  direction  width  meaning) SHALL be:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line-fill request
- i_addr  in  16  I-cache line address (lc3b_word)
- i_resp  out  1  I-cache completion pulse
- i_rdata  out  128  line to I-cache (lc3b_block)
- d_read  in  1  D-cache line-fill request
- d_write  in  1  D-cache write-back request
- d_addr  in  16  D-cache line address
- d_wdata  in  128  write-back line
- d_resp  out  1  D-cache completion pulse
- d_rdata  out  128  line to D-cache
- pmem_read  out  1  shared memory read strobe
- pmem_write  out  1  shared memory write strobe
- pmem_address  out  16  shared memory address
- pmem_wdata  out  128  shared memory write data
- pmem_rdata  in  128  shared memory read data
- pmem_resp  in  1  shared memory completion pulse
- conflict_count  out  16  saturating count of cycles with both caches requesting
- clr_count  in  1  synchronous clear of conflict_count

Function
REQ-003 The FSM SHALL have states IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE -> SERVE_I or SERVE_D on a grant
- SERVE_x -> RELEASE on pmem_resp
- RELEASE -> IDLE unconditionally
REQ-004 Grant in IDLE: if one cache requests, it SHALL be granted; if both request, the cache not granted last SHALL be granted. last_grant resets to I, so D wins the first conflict.
REQ-005 A D request SHALL be active when d_read or d_write is 1; d_read and d_write both 1 is illegal, and d_write SHALL take precedence.
REQ-006 On grant the block SHALL register the address, the write data and the read/write type. pmem_* SHALL be driven from these registers only, so requester changes during service are ignored.
REQ-007 pmem_read or pmem_write SHALL be asserted in every SERVE_x cycle, including the pmem_resp cycle, and deasserted in IDLE and RELEASE.
REQ-008 Latency: a grant decided in IDLE at edge N SHALL assert the strobe from cycle N+1. At least one strobe-free cycle (RELEASE) SHALL separate consecutive transactions.
REQ-009 i_resp/d_resp SHALL be pmem_resp gated combinationally by the served requester, and be 1 for exactly one cycle. The other resp SHALL stay 0.
REQ-010 i_rdata and d_rdata SHALL both equal pmem_rdata combinationally; they are valid only while the matching resp is 1.
REQ-011 Requesters SHALL drop their request in the resp cycle. The RELEASE cycle guarantees a stale request is never re-granted.
REQ-012 pmem_resp outside SERVE_x SHALL be ignored: no resp output and no state change.
REQ-013 conflict_count SHALL increment by 1 in each cycle where both caches request (any state), saturate at 16'hFFFF, and clear when clr_count=1. Clear wins over increment.

Reset
REQ-014 While rst_n=0, regardless of clk, the block SHALL hold:
- state=IDLE and last_grant=I
- all registered address/data/type bits = 0
- conflict_count = 0
- pmem_read/pmem_write = 0, i_resp/d_resp = 0
REQ-015 A reset during SERVE_x SHALL abandon the transaction without any resp. The first grant after deassertion follows REQ-004.

Structure
REQ-016 The arbiter state enum (arb_state_t) and the requester-select type SHALL be added to lc3b_types. The 16-bit saturation limit SHALL be a package constant.
REQ-017 The saturating counter SHALL be a sub-module, sat_counter16, reused by future performance counters. Everything else stays in cache_arbiter.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Lone I read at 16'h0040, memory latency 3 -> pmem_read for 3 cycles at address 16'h0040; i_resp one pulse carrying the line; d_resp stays 0.
- I read and D write asserted together (D addr 16'h1000, data 128'hA5..A5) just after reset -> D served first with pmem_write; after RELEASE, I served; conflict_count = number of overlap cycles.
- Three back-to-back simultaneous conflicts -> grants alternate D, I, D.
- d_addr changed mid-service -> pmem_address holds the latched value.
- Spurious pmem_resp in IDLE -> no resp output.
- rst_n dropped mid-SERVE_D -> outputs zero immediately, no d_resp.
- conflict_count preloaded near 16'hFFFF with a sustained conflict -> holds at 16'hFFFF.
- clr_count=1 during a conflict -> count becomes 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory word/line widths plus the cache-arbiter state and requester encodings.
// Combinational-free package; no latency or backpressure of its own.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_sel_t;

  localparam logic [15:0] SAT_LIMIT16 = 16'hFFFF;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter; counts on i_inc, one cycle latency to o_count.
// Never stalls: i_clr wins over i_inc, and the count sticks at SAT_LIMIT16.
module sat_counter16
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != SAT_LIMIT16)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line fills/write-backs onto one memory port; strobe one cycle after grant.
// Requesters wait in place until their resp pulse; a RELEASE cycle separates every pair of transactions.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_read,
  input  lc3b_word   i_addr,
  output logic       i_resp,
  output lc3b_block  i_rdata,
  input  logic       d_read,
  input  logic       d_write,
  input  lc3b_word   d_addr,
  input  lc3b_block  d_wdata,
  output logic       d_resp,
  output lc3b_block  d_rdata,
  output logic       pmem_read,
  output logic       pmem_write,
  output lc3b_word   pmem_address,
  output lc3b_block  pmem_wdata,
  input  lc3b_block  pmem_rdata,
  input  logic       pmem_resp,
  output logic [15:0] conflict_count,
  input  logic       clr_count
);

  arb_state_t r_state;
  req_sel_t   r_last_grant;
  lc3b_word   r_addr;
  lc3b_block  r_wdata;
  logic       r_pmem_read;
  logic       r_pmem_write;

  logic       w_i_req;
  logic       w_d_req;
  logic       w_conflict;
  req_sel_t   w_grant;

  assign w_i_req    = i_read;
  assign w_d_req    = d_read | d_write;
  assign w_conflict = w_i_req & w_d_req;

  // On a tie, whoever was not served last goes next.
  always_comb begin
    w_grant = REQ_I;
    if (w_conflict) begin
      w_grant = (r_last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (w_d_req) begin
      w_grant = REQ_D;
    end
  end

  // The strobe registers double as the latched read/write type of the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= REQ_I;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_i_req || w_d_req) begin
            r_last_grant <= w_grant;
            if (w_grant == REQ_D) begin
              r_state      <= ARB_SERVE_D;
              r_addr       <= d_addr;
              r_wdata      <= d_wdata;
              r_pmem_read  <= ~d_write;
              r_pmem_write <= d_write;
            end else begin
              r_state      <= ARB_SERVE_I;
              r_addr       <= i_addr;
              r_wdata      <= '0;
              r_pmem_read  <= 1'b1;
              r_pmem_write <= 1'b0;
            end
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (pmem_resp) begin
            r_state      <= ARB_RELEASE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
        ARB_RELEASE: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  assign i_resp  = pmem_resp & (r_state == ARB_SERVE_I);
  assign d_resp  = pmem_resp & (r_state == ARB_SERVE_D);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  sat_counter16 u_conflict_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_conflict),
    .i_clr   (clr_count),
    .o_count (conflict_count)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: per-cycle vector table plus hand sequences for reset and counter corners.
module tb_cache_arbiter;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  lc3b_word    i_addr;
  logic        i_resp;
  lc3b_block   i_rdata;
  logic        d_read;
  logic        d_write;
  lc3b_word    d_addr;
  lc3b_block   d_wdata;
  logic        d_resp;
  lc3b_block   d_rdata;
  logic        pmem_read;
  logic        pmem_write;
  lc3b_word    pmem_address;
  lc3b_block   pmem_wdata;
  lc3b_block   pmem_rdata;
  logic        pmem_resp;
  logic [15:0] conflict_count;
  logic        clr_count;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_read         (i_read),
    .i_addr         (i_addr),
    .i_resp         (i_resp),
    .i_rdata        (i_rdata),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_resp         (d_resp),
    .d_rdata        (d_rdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .conflict_count (conflict_count),
    .clr_count      (clr_count)
  );

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [127:0] dwd;
    logic [127:0] prd;
    logic        prs;
    logic        er;
    logic        ew;
    logic [15:0] ea;
    logic [127:0] ewd;
    logic        eir;
    logic        edr;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_model;

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] X5A = {16{8'h5A}};
  localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] L2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] L3 = 128'hDEAD_BEEF_0000_0001_DEAD_BEEF_0000_0002;
  localparam logic [127:0] L4 = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0;
  localparam logic [127:0] L5 = 128'h0BAD_C0DE_AAAA_5555_0000_FFFF_1357_2468;
  localparam logic [127:0] L6 = 128'h4040_4040_0000_0040_0000_0040_4040_4040;
  localparam logic [127:0] L7 = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
  localparam logic [127:0] L8 = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001;
  localparam logic [127:0] L9 = 128'h00A0_00A0_00A0_00A0_00A0_00A0_00A0_00A0;

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                              input logic [15:0] da, input logic [127:0] dwd, input logic [127:0] prd,
                              input logic prs, input logic er, input logic ew, input logic [15:0] ea,
                              input logic [127:0] ewd, input logic eir, input logic edr);
    vec_t v;
    v.ir = ir;  v.ia = ia;  v.dr = dr;  v.dw = dw;  v.da = da;  v.dwd = dwd;
    v.prd = prd; v.prs = prs; v.er = er; v.ew = ew; v.ea = ea; v.ewd = ewd;
    v.eir = eir; v.edr = edr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    i_read     = v.ir;
    i_addr     = v.ia;
    d_read     = v.dr;
    d_write    = v.dw;
    d_addr     = v.da;
    d_wdata    = v.dwd;
    pmem_rdata = v.prd;
    pmem_resp  = v.prs;
    clr_count  = 1'b0;
    @(negedge clk);
    chk($sformatf("row%0d pmem_read", idx), pmem_read, v.er);
    chk($sformatf("row%0d pmem_write", idx), pmem_write, v.ew);
    if (v.er || v.ew) chk($sformatf("row%0d pmem_address", idx), pmem_address, v.ea);
    if (v.ew) chk($sformatf("row%0d pmem_wdata", idx), pmem_wdata, v.ewd);
    chk($sformatf("row%0d i_resp", idx), i_resp, v.eir);
    chk($sformatf("row%0d d_resp", idx), d_resp, v.edr);
    if (v.eir) chk($sformatf("row%0d i_rdata", idx), i_rdata, v.prd);
    if (v.edr) chk($sformatf("row%0d d_rdata", idx), d_rdata, v.prd);
    chk($sformatf("row%0d conflict_count", idx), conflict_count, cnt_model);
    @(posedge clk);
    if (i_read && (d_read || d_write) && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0; clr_count = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    cnt_model = '0;

    // Scenario: I read + D write together right after reset (rows 0-7)
    tbl.push_back(mk(1,16'h0200,0,1,16'h1000,A5, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h0200,0,1,16'h1000,A5, '0,0, 0,1,16'h1000,A5, 0,0));
    tbl.push_back(mk(1,16'h0200,0,0,16'h1000,A5, L1,1, 0,1,16'h1000,A5, 0,1));
    tbl.push_back(mk(1,16'h0200,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h0200,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h0200,0,0,16'h0000,'0, '0,0, 1,0,16'h0200,'0, 0,0));
    tbl.push_back(mk(0,16'h0200,0,0,16'h0000,'0, L2,1, 1,0,16'h0200,'0, 1,0));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    // Three back-to-back conflicts: D, I, D (rows 8-16)
    tbl.push_back(mk(1,16'h0300,1,0,16'h2000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h0300,0,0,16'h2000,'0, L3,1, 1,0,16'h2000,'0, 0,1));
    tbl.push_back(mk(1,16'h0300,1,0,16'h2000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h0300,1,0,16'h2000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(0,16'h0300,1,0,16'h2000,'0, L4,1, 1,0,16'h0300,'0, 1,0));
    tbl.push_back(mk(1,16'h0300,1,0,16'h2000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h0300,1,0,16'h2000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h0300,0,0,16'h2000,'0, L5,1, 1,0,16'h2000,'0, 0,1));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    // Lone I read at 0x0040, memory latency 3
    tbl.push_back(mk(1,16'h0040,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h0040,0,0,16'h0000,'0, '0,0, 1,0,16'h0040,'0, 0,0));
    tbl.push_back(mk(1,16'h0040,0,0,16'h0000,'0, '0,0, 1,0,16'h0040,'0, 0,0));
    tbl.push_back(mk(0,16'h0040,0,0,16'h0000,'0, L6,1, 1,0,16'h0040,'0, 1,0));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    // D write whose address/data change mid-service
    tbl.push_back(mk(0,16'h0000,0,1,16'h1234,X5A, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(0,16'h0000,0,1,16'hFFFF,'0, '0,0, 0,1,16'h1234,X5A, 0,0));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0BAD,'0, L7,1, 0,1,16'h1234,X5A, 0,1));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    // Spurious pmem_resp in IDLE, then a normal I read proves state did not move
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,'0, L8,1, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,'0, L8,1, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(1,16'h00A0,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));
    tbl.push_back(mk(0,16'h00A0,0,0,16'h0000,'0, L9,1, 1,0,16'h00A0,'0, 1,0));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,'0, '0,0, 0,0,16'h0000,'0, 0,0));

    #12;
    chk("reset pmem_read", pmem_read, 1'b0);
    chk("reset pmem_write", pmem_write, 1'b0);
    chk("reset pmem_address", pmem_address, 16'h0000);
    chk("reset conflict_count", conflict_count, 16'h0000);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) apply_row(tbl[k], k);
    chk("overlap conflict_count", conflict_count, 16'd2);
    for (int k = 8; k < tbl.size(); k++) apply_row(tbl[k], k);
    chk("after table conflict_count", conflict_count, 16'd7);

    // Reset dropped mid-SERVE_D
    d_write = 1; d_addr = 16'h4444; d_wdata = A5;
    @(posedge clk); #1;
    chk("pre-reset pmem_write", pmem_write, 1'b1);
    pmem_resp = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid-reset pmem_write", pmem_write, 1'b0);
    chk("mid-reset pmem_read", pmem_read, 1'b0);
    chk("mid-reset d_resp", d_resp, 1'b0);
    chk("mid-reset pmem_address", pmem_address, 16'h0000);
    chk("mid-reset pmem_wdata", pmem_wdata, 128'h0);
    chk("mid-reset conflict_count", conflict_count, 16'h0000);
    @(posedge clk); #1;
    chk("held-reset d_resp", d_resp, 1'b0);
    idle_inputs();
    #2 rst_n = 1'b1;

    // First conflict after reset goes to D; then clear during a sustained conflict
    i_read = 1; i_addr = 16'h6666; d_read = 1; d_addr = 16'h5555;
    @(posedge clk); #1;
    chk("post-reset grant pmem_read", pmem_read, 1'b1);
    chk("post-reset grant address", pmem_address, 16'h5555);
    @(posedge clk); @(posedge clk); #1;
    chk("conflict count before clear", conflict_count, 16'd3);
    clr_count = 1'b1;
    @(posedge clk); #1;
    chk("conflict count on clear", conflict_count, 16'd0);
    clr_count = 1'b0;
    @(posedge clk); #1;
    chk("conflict count after clear", conflict_count, 16'd1);

    // Sustained conflict runs the counter up to its ceiling
    repeat (65529) @(posedge clk);
    #1;
    chk("conflict count near limit", conflict_count, 16'hFFFA);
    repeat (10) @(posedge clk);
    #1;
    chk("conflict count saturated", conflict_count, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("conflict count holds", conflict_count, 16'hFFFF);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
